// File: rtl/display_scanner_if.sv
// display_scanner_if: value/load strobe toward the scanner and the scanned
// digit/select/pending outputs back toward the display side.
// The master side owns value and load; the slave (the scanner) owns the outputs.
// Handshake: there is no valid/ready pair. load is a one-cycle strobe sampled
// on the rising clock edge. digit/select/pending are always valid, and they
// change only on clock edges or on reset.
interface display_scanner_if;
    logic [15:0] value;
    logic        load;
    logic [3:0]  digit;
    logic [3:0]  select;
    logic        pending;

    modport master (
        output value,
        output load,
        input  digit,
        input  select,
        input  pending
    );

    modport slave (
        input  value,
        input  load,
        output digit,
        output select,
        output pending
    );
endinterface

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed driver for a four-digit seven-segment
// display. It steps one scan slot every PRESCALE clocks and presents that
// slot's BCD nibble on digit, together with a one-hot select.
// A loaded value is held in a shadow register and takes effect only at the
// frame boundary, so a frame never mixes old and new digits.
// Optional feature macro: DISPLAY_SCANNER_LEADING_ZERO_BLANK_EN. When it is
// defined, leading zero digits (slots 1..3) are shown as blank (4'hF).
module display_scanner #(
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset,
    display_scanner_if.slave  bus
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(PRESCALE - 1);

    // Scan slot encodings (slot index doubles as the scan state).
    localparam logic [1:0] SLOT_0 = 2'd0;
    localparam logic [1:0] SLOT_3 = 2'd3;

    logic [CW-1:0] count;
    logic [1:0]    idx;
    logic [15:0]   shown;
    logic [15:0]   shadow;
    logic          pending_q;
    logic [3:0]    select_q;
    logic [3:0]    digit_q;

    logic          tick;
    logic          boundary;
    logic [1:0]    idx_next;
    logic [15:0]   shown_next;
    logic [15:0]   shadow_next;
    logic          pending_next;
    logic [3:0]    select_next;
    logic [3:0]    digit_next;

    // Nibble shown in slot s for display word v, with optional leading-zero
    // blanking. Slot 0 is never blanked, so a zero value still shows "0".
    function automatic logic [3:0] slot_digit(input logic [15:0] v, input logic [1:0] s);
        logic [3:0] nib;
        nib = v[{s, 2'b00} +: 4];
`ifdef DISPLAY_SCANNER_LEADING_ZERO_BLANK_EN
        case (s)
            2'd1:    if (v[15:4] == 12'h000) nib = 4'hF;
            2'd2:    if (v[15:8] == 8'h00) nib = 4'hF;
            2'd3:    if (v[15:12] == 4'h0) nib = 4'hF;
            default: nib = v[3:0];
        endcase
`endif
        return nib;
    endfunction

    // Tick, frame boundary and next-state values for the slot, the display
    // and shadow words, and the outputs.
    always_comb begin
        tick         = (count == COUNT_LAST);
        boundary     = tick && (idx == SLOT_3);
        idx_next     = tick ? idx + 2'd1 : idx;
        shown_next   = shown;
        shadow_next  = shadow;
        pending_next = pending_q;

        if (boundary) begin
            // A load on the boundary bypasses the shadow; otherwise a pending
            // shadow value is committed. Either way nothing stays pending.
            if (bus.load) begin
                shown_next = bus.value;
            end else if (pending_q) begin
                shown_next = shadow;
            end
            pending_next = 1'b0;
        end else if (bus.load) begin
            shadow_next  = bus.value;
            pending_next = 1'b1;
        end

        select_next = 4'b0001 << idx_next;
        digit_next  = slot_digit(shown_next, idx_next);
    end

    // Prescaler: count to PRESCALE-1, then wrap to zero on the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Slot index advances modulo 4 on each tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= SLOT_0;
        end else begin
            idx <= idx_next;
        end
    end

    // Display, shadow and pending registers. Reset discards any pending load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shown     <= 16'h0000;
            shadow    <= 16'h0000;
            pending_q <= 1'b0;
        end else begin
            shown     <= shown_next;
            shadow    <= shadow_next;
            pending_q <= pending_next;
        end
    end

    // Output registers: update only on a tick and hold between ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            select_q <= 4'b0001;
            digit_q  <= 4'h0;
        end else if (tick) begin
            select_q <= select_next;
            digit_q  <= digit_next;
        end
    end

    assign bus.digit   = digit_q;
    assign bus.select  = select_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: scoreboard bench for display_scanner with PRESCALE=4.
// The driver issues one input per clock cycle and pushes the expected
// {pending, select, digit} for that edge, using a time-based model: slot =
// (edges since reset / PRESCALE) mod 4, and loads commit on multiples of
// 4*PRESCALE. A monitor pops and compares these values after each rising edge.
module tb_display_scanner;
    localparam int P     = 4;
    localparam int FRAME = 4 * P;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    // Clock and reset
    always #5 clk = ~clk;

    display_scanner_if bus ();

    display_scanner #(.PRESCALE(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [8:0]  exp_q[$];
    int          tag_q[$];

    // Reference model state
    int          t;
    logic [15:0] m_shown;
    logic [15:0] m_latest;
    bit          m_new;

    function automatic logic [3:0] exp_digit(input logic [15:0] v, input int slot);
        logic [15:0] upper;
        upper = v >> (4 * slot);
`ifdef DISPLAY_SCANNER_LEADING_ZERO_BLANK_EN
        if (slot > 0 && upper == 16'h0000) return 4'hF;
`endif
        return upper[3:0];
    endfunction

    function automatic logic [8:0] model_out();
        int slot;
        logic [3:0] sel;
        slot = (t / P) % 4;
        sel  = 4'(1 << slot);
        return {m_new, sel, exp_digit(m_shown, slot)};
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got pending=%b select=%b digit=%h, expected pending=%b select=%b digit=%h",
                     name, got[8], got[7:4], got[3:0], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    // Driver: called at a falling edge. It sets the inputs, advances the model
    // by one edge, queues the expected outputs and waits for the next falling edge.
    task automatic drive_cycle(input bit ld, input logic [15:0] v);
        bus.load  = ld;
        bus.value = v;
        t++;
        if (ld) begin
            m_latest = v;
            m_new    = 1'b1;
        end
        if (t % FRAME == 0 && m_new) begin
            m_shown = m_latest;
            m_new   = 1'b0;
        end
        exp_q.push_back(model_out());
        tag_q.push_back(t);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0000);
    endtask

    task automatic load_on_boundary(input logic [15:0] v);
        while ((t + 1) % FRAME != 0) drive_cycle(1'b0, 16'h0000);
        drive_cycle(1'b1, v);
    endtask

    // Asserts reset at a falling edge, checks the asynchronous response,
    // then releases reset at the next falling edge.
    task automatic do_reset();
        bus.load = 1'b0;
        reset    = 1'b1;
        #1;
        check("async_reset", {bus.pending, bus.select, bus.digit}, 9'b0_0001_0000);
        @(negedge clk);
        check("reset_hold", {bus.pending, bus.select, bus.digit}, 9'b0_0001_0000);
        reset    = 1'b0;
        t        = 0;
        m_shown  = 16'h0000;
        m_latest = 16'h0000;
        m_new    = 1'b0;
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        logic [8:0] e;
        int         c;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = tag_q.pop_front();
            check($sformatf("scan_t%0d", c), {bus.pending, bus.select, bus.digit}, e);
        end
    end

    // Stimulus
    initial begin
        bus.load  = 1'b0;
        bus.value = 16'h0000;
        t         = 0;
        @(negedge clk);
        do_reset();

        // Reset in the middle of a slot; after release the first advance
        // comes exactly P edges later.
        idle(6);
        do_reset();
        idle(2 * FRAME);

        // Scan order
        load_on_boundary(16'h1234);
        idle(FRAME + 4);

        // Shadowing: load while slot 1 is showing 1234
        while ((t / P) % 4 != 1) drive_cycle(1'b0, 16'h0000);
        drive_cycle(1'b1, 16'h5678);
        idle(FRAME + 4);

        // Last load wins
        while ((t + 1) % FRAME != 2) drive_cycle(1'b0, 16'h0000);
        drive_cycle(1'b1, 16'h1111);
        idle(3);
        drive_cycle(1'b1, 16'h2222);
        idle(2 * FRAME);

        // Simultaneous load and boundary
        load_on_boundary(16'h9ABC);
        idle(FRAME);

        // Blanking cases
        load_on_boundary(16'h0007);
        idle(FRAME);
        load_on_boundary(16'h0000);
        idle(FRAME);
        drive_cycle(1'b1, 16'h0042);
        idle(2 * FRAME);

        // Randomized loads
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)
                drive_cycle(1'b1, 16'($urandom));
            else
                drive_cycle(1'b0, 16'($urandom));
        end

        // Reset with a load pending: the load is discarded
        while ((t + 1) % FRAME != 5) drive_cycle(1'b0, 16'h0000);
        drive_cycle(1'b1, 16'h4321);
        idle(2);
        do_reset();
        idle(2 * FRAME);

        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
